// File: rtl/tb_run_ctrl.sv
// Simulation run controller: holds tb_top in reset, releases it, then watches for
// completion, global timeout and progress stall, latching a sticky verdict.
module tb_run_ctrl #(
  parameter int RESET_CYCLES   = 10,
  parameter int TIMEOUT_CYCLES = 20,
  parameter int STALL_CYCLES   = 8,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             dut_progress,
  input  logic             dut_done,
  input  logic             dut_pass,
  output logic             dut_rst_n,
  output logic             running,
  output logic             finished,
  output logic             pass,
  output logic             timeout,
  output logic             stall,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [2:0] {ST_HOLD, ST_RUN, ST_DONE, ST_TIMEOUT, ST_STALL} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam bit               STALL_EN   = (STALL_CYCLES != 0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [CNT_W-1:0] stall_cnt, stall_cnt_nxt;
  logic [CNT_W-1:0] cycle_cnt_nxt;
  logic             dut_rst_n_nxt, finished_nxt, pass_nxt, timeout_nxt, stall_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_HOLD;
      hold_cnt  <= '0;
      stall_cnt <= '0;
      cycle_cnt <= '0;
      dut_rst_n <= 1'b0;
      running   <= 1'b0;
      finished  <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      stall     <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_cnt_nxt;
      stall_cnt <= stall_cnt_nxt;
      cycle_cnt <= cycle_cnt_nxt;
      dut_rst_n <= dut_rst_n_nxt;
      running   <= (state_nxt == ST_RUN);
      finished  <= finished_nxt;
      pass      <= pass_nxt;
      timeout   <= timeout_nxt;
      stall     <= stall_nxt;
    end
  end

  // Exit checks use pre-increment counter values; done outranks timeout outranks stall.
  always_comb begin
    state_nxt = state;
    if (restart) begin
      state_nxt = ST_HOLD;
    end else begin
      case (state)
        ST_HOLD: if (hold_cnt == HOLD_LAST) state_nxt = ST_RUN;
        ST_RUN: begin
          if (dut_done)
            state_nxt = ST_DONE;
          else if (cycle_cnt == TO_LAST)
            state_nxt = ST_TIMEOUT;
          else if (STALL_EN && !dut_progress && stall_cnt == STALL_LAST)
            state_nxt = ST_STALL;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    hold_cnt_nxt  = hold_cnt;
    stall_cnt_nxt = stall_cnt;
    cycle_cnt_nxt = cycle_cnt;
    dut_rst_n_nxt = dut_rst_n;
    finished_nxt  = finished;
    pass_nxt      = pass;
    timeout_nxt   = timeout;
    stall_nxt     = stall;
    if (restart) begin
      hold_cnt_nxt  = '0;
      stall_cnt_nxt = '0;
      cycle_cnt_nxt = '0;
      dut_rst_n_nxt = 1'b0;
      finished_nxt  = 1'b0;
      pass_nxt      = 1'b0;
      timeout_nxt   = 1'b0;
      stall_nxt     = 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          hold_cnt_nxt = hold_cnt + 1'b1;
          if (state_nxt == ST_RUN) dut_rst_n_nxt = 1'b1;
        end
        ST_RUN: begin
          cycle_cnt_nxt = (cycle_cnt == CNT_MAX) ? cycle_cnt : cycle_cnt + 1'b1;
          stall_cnt_nxt = dut_progress ? '0 : stall_cnt + 1'b1;
          finished_nxt  = (state_nxt == ST_DONE);
          pass_nxt      = (state_nxt == ST_DONE) && dut_pass;
          timeout_nxt   = (state_nxt == ST_TIMEOUT);
          stall_nxt     = (state_nxt == ST_STALL);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tb_run_ctrl.sv
// Randomized scoreboard bench for tb_run_ctrl; a second instance runs with the
// stall watchdog disabled so both watchdog configurations are covered.
module tb_tb_run_ctrl;

  localparam int RESET_CYCLES   = 10;
  localparam int TIMEOUT_CYCLES = 20;

  typedef struct packed {
    logic        rstn;
    logic        running;
    logic        finished;
    logic        pass;
    logic        timeout;
    logic        stall;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst, restart, dut_progress, dut_done, dut_pass;

  logic        rstn0, run0, fin0, pass0, to0, st0;
  logic [31:0] cnt0;
  logic        rstn1, run1, fin1, pass1, to1, st1;
  logic [31:0] cnt1;

  int checks = 0;
  int errors = 0;

  exp_t sb_q0[$];
  exp_t sb_q1[$];

  // Reference model: elapsed-count view of the run, one slot per instance.
  int     stall_lim[2] = '{8, 0};
  bit     m_in_hold[2];
  int     m_hold_elapsed[2];
  longint m_run[2];
  int     m_since[2];
  bit     m_fin[2], m_pass[2], m_to[2], m_st[2], m_rstn[2];

  always #5 clk = ~clk;

  tb_run_ctrl #(.RESET_CYCLES(10), .TIMEOUT_CYCLES(20), .STALL_CYCLES(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .restart(restart), .dut_progress(dut_progress),
    .dut_done(dut_done), .dut_pass(dut_pass), .dut_rst_n(rstn0), .running(run0),
    .finished(fin0), .pass(pass0), .timeout(to0), .stall(st0), .cycle_cnt(cnt0)
  );

  tb_run_ctrl #(.RESET_CYCLES(10), .TIMEOUT_CYCLES(20), .STALL_CYCLES(0), .CNT_W(32)) dut_ns (
    .clk(clk), .rst(rst), .restart(restart), .dut_progress(dut_progress),
    .dut_done(dut_done), .dut_pass(dut_pass), .dut_rst_n(rstn1), .running(run1),
    .finished(fin1), .pass(pass1), .timeout(to1), .stall(st1), .cycle_cnt(cnt1)
  );

  function automatic void modelStep(int k, bit r, bit rs, bit prog, bit dn, bit ps);
    longint pre_run;
    int     pre_since;
    if (r || rs) begin
      m_in_hold[k] = 1; m_hold_elapsed[k] = 0; m_run[k] = 0; m_since[k] = 0;
      m_fin[k] = 0; m_pass[k] = 0; m_to[k] = 0; m_st[k] = 0; m_rstn[k] = 0;
    end else if (m_in_hold[k]) begin
      m_hold_elapsed[k]++;
      if (m_hold_elapsed[k] == RESET_CYCLES) begin
        m_in_hold[k] = 0;
        m_rstn[k] = 1;
      end
    end else if (!(m_fin[k] || m_to[k] || m_st[k])) begin
      pre_run   = m_run[k];
      pre_since = m_since[k];
      m_run[k]   = (m_run[k] == 64'hFFFF_FFFF) ? m_run[k] : m_run[k] + 1;
      m_since[k] = prog ? 0 : m_since[k] + 1;
      if (dn) begin
        m_fin[k] = 1; m_pass[k] = ps;
      end else if (pre_run + 1 == TIMEOUT_CYCLES) begin
        m_to[k] = 1;
      end else if (stall_lim[k] != 0 && !prog && pre_since + 1 == stall_lim[k]) begin
        m_st[k] = 1;
      end
    end
  endfunction

  function automatic exp_t modelOut(int k);
    exp_t e;
    e.rstn     = m_rstn[k];
    e.running  = !m_in_hold[k] && !(m_fin[k] || m_to[k] || m_st[k]);
    e.finished = m_fin[k];
    e.pass     = m_pass[k];
    e.timeout  = m_to[k];
    e.stall    = m_st[k];
    e.cnt      = m_run[k][31:0];
    return e;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compareAll(string tag, exp_t a, exp_t e);
    checkOutput({tag, ".dut_rst_n"}, 32'(a.rstn), 32'(e.rstn));
    checkOutput({tag, ".running"},   32'(a.running), 32'(e.running));
    checkOutput({tag, ".finished"},  32'(a.finished), 32'(e.finished));
    checkOutput({tag, ".pass"},      32'(a.pass), 32'(e.pass));
    checkOutput({tag, ".timeout"},   32'(a.timeout), 32'(e.timeout));
    checkOutput({tag, ".stall"},     32'(a.stall), 32'(e.stall));
    checkOutput({tag, ".cycle_cnt"}, a.cnt, e.cnt);
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, then let the edge happen.
  task automatic applyStimulus(bit r, bit rs, bit prog, bit dn, bit ps);
    rst = r; restart = rs; dut_progress = prog; dut_done = dn; dut_pass = ps;
    for (int k = 0; k < 2; k++) modelStep(k, r, rs, prog, dn, ps);
    sb_q0.push_back(modelOut(0));
    sb_q1.push_back(modelOut(1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n, bit prog);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, prog, 0, 0);
  endtask

  always @(negedge clk) begin
    if (sb_q0.size() > 0) compareAll("i0", {rstn0, run0, fin0, pass0, to0, st0, cnt0}, sb_q0.pop_front());
    if (sb_q1.size() > 0) compareAll("i1", {rstn1, run1, fin1, pass1, to1, st1, cnt1}, sb_q1.pop_front());
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int prob;
    rst = 1; restart = 0; dut_progress = 0; dut_done = 0; dut_pass = 0;

    $display("[TB] reset release timing");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 0);
    checkOutput("reset.dut_rst_n", 32'(rstn0), 0);
    checkOutput("reset.cycle_cnt", cnt0, 0);
    idle(9, 1);
    checkOutput("hold9.dut_rst_n", 32'(rstn0), 0);
    idle(1, 1);
    checkOutput("hold10.dut_rst_n", 32'(rstn0), 1);
    checkOutput("hold10.running", 32'(run0), 1);

    $display("[TB] done at RUN cycle 5");
    idle(5, 1);
    applyStimulus(0, 0, 1, 1, 1);
    checkOutput("done.finished", 32'(fin0), 1);
    checkOutput("done.pass", 32'(pass0), 1);
    checkOutput("done.cycle_cnt", cnt0, 6);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 0);
    checkOutput("done.frozen_cnt", cnt0, 6);

    $display("[TB] global timeout");
    applyStimulus(0, 1, 0, 0, 0);
    idle(RESET_CYCLES, 1);
    idle(TIMEOUT_CYCLES, 1);
    checkOutput("to.timeout", 32'(to0), 1);
    checkOutput("to.cycle_cnt", cnt0, 20);
    checkOutput("to.finished", 32'(fin0), 0);

    $display("[TB] progress stall");
    applyStimulus(0, 1, 0, 0, 0);
    idle(RESET_CYCLES, 0);
    idle(8, 0);
    checkOutput("stall.stall", 32'(st0), 1);
    checkOutput("stall.cycle_cnt", cnt0, 8);
    checkOutput("stall_off.running", 32'(run1), 1);
    idle(12, 0);
    checkOutput("stall_off.timeout", 32'(to1), 1);
    checkOutput("stall_off.cycle_cnt", cnt1, 20);

    $display("[TB] done vs timeout, done vs restart");
    applyStimulus(0, 1, 0, 0, 0);
    idle(RESET_CYCLES, 1);
    idle(TIMEOUT_CYCLES - 1, 1);
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("race.finished", 32'(fin0), 1);
    checkOutput("race.timeout", 32'(to0), 0);
    checkOutput("race.cycle_cnt", cnt0, 20);
    applyStimulus(0, 1, 0, 0, 0);
    idle(RESET_CYCLES + 3, 1);
    applyStimulus(0, 1, 1, 1, 1);
    checkOutput("rs_done.finished", 32'(fin0), 0);
    checkOutput("rs_done.dut_rst_n", 32'(rstn0), 0);

    $display("[TB] restart mid-run");
    idle(RESET_CYCLES + 7, 1);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("rs7.dut_rst_n", 32'(rstn0), 0);
    checkOutput("rs7.cycle_cnt", cnt0, 0);
    idle(RESET_CYCLES - 1, 1);
    checkOutput("rs7.hold", 32'(rstn0), 0);
    idle(1, 1);
    checkOutput("rs7.resume", 32'(run0), 1);

    $display("[TB] randomized traffic");
    prob = 7;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) prob = $urandom_range(10);
      applyStimulus($urandom_range(199) == 0, $urandom_range(79) == 0,
                    $urandom_range(9) < prob, $urandom_range(29) == 0,
                    1'($urandom_range(1)));
    end

    for (int i = 0; i < 5 && (sb_q0.size() > 0 || sb_q1.size() > 0); i++) @(negedge clk);
    #1;
    checkOutput("scoreboard.drained", 32'(sb_q0.size() + sb_q1.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
